// File: rtl/fp8_div_sched.sv
`default_nettype none
// ============================================================================
// Module  : fp8_div_sched
// Brief   : Round-robin scheduler sharing one pipelined FP8 (E4M3) divider among
//           NUM_REQ requesters. Define FP8_DIV_SCHED_DIVZERO_EN for divide-by-zero
//           detection with saturated results and a per-response dz flag.
// Rev     : 1.0  initial release
// ============================================================================
module fp8_div_sched #(
    parameter int NUM_REQ = 4,
    parameter int DIV_LAT = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    input  logic [8*NUM_REQ-1:0] req_a_i,
    input  logic [8*NUM_REQ-1:0] req_b_i,
    output logic [NUM_REQ-1:0]   rsp_valid_o,
    input  logic [NUM_REQ-1:0]   rsp_ready_i,
    output logic [8*NUM_REQ-1:0] rsp_result_o,
    output logic [NUM_REQ-1:0]   rsp_dz_o,
    output logic                 div_valid_o,
    output logic [7:0]           div_a_o,
    output logic [7:0]           div_b_o,
    input  logic [7:0]           div_result_i
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            busy_q, busy_d;
    logic [ID_W-1:0]               last_grant_q;
    logic [DIV_LAT-1:0]            tag_vld_q;
    logic [DIV_LAT-1:0][ID_W-1:0]  tag_id_q;
    logic [NUM_REQ-1:0]            rsp_valid_q;
    logic [NUM_REQ-1:0][7:0]       rsp_result_q;

    logic [NUM_REQ-1:0] eligible_w;
    logic [NUM_REQ-1:0] grant_oh_w;
    logic [NUM_REQ-1:0] rsp_hs_w;
    logic               issue_w;
    logic [ID_W-1:0]    grant_id_w;
    logic [7:0]         win_a_w;
    logic [7:0]         win_b_w;
    logic               cap_w;
    logic [ID_W-1:0]    cap_id_w;
    logic [7:0]         cap_res_w;
    int                 cand_w;

    // Outputs must read zero while reset is held, so eligibility is gated by rst_ni.
    always_comb begin
        eligible_w = req_valid_i & ~busy_q & {NUM_REQ{rst_ni}};
        issue_w    = 1'b0;
        grant_id_w = '0;
        cand_w     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_w = (int'(last_grant_q) + k) % NUM_REQ;
            if (!issue_w && eligible_w[cand_w[ID_W-1:0]]) begin
                issue_w    = 1'b1;
                grant_id_w = cand_w[ID_W-1:0];
            end
        end
        grant_oh_w = '0;
        win_a_w    = '0;
        win_b_w    = '0;
        if (issue_w) begin
            grant_oh_w[grant_id_w] = 1'b1;
            win_a_w = req_a_i[8*grant_id_w +: 8];
            win_b_w = req_b_i[8*grant_id_w +: 8];
        end
    end

    assign rsp_hs_w = rsp_valid_q & rsp_ready_i;
    assign busy_d   = (busy_q & ~rsp_hs_w) | grant_oh_w;
    assign cap_w    = tag_vld_q[DIV_LAT-1];
    assign cap_id_w = tag_id_q[DIV_LAT-1];

`ifdef FP8_DIV_SCHED_DIVZERO_EN
    logic [DIV_LAT-1:0] tag_dz_q;
    logic [DIV_LAT-1:0] tag_sgn_q;
    logic [NUM_REQ-1:0] rsp_dz_q;

    // Zero divisor still takes a divider slot; the quotient is replaced on return.
    assign cap_res_w = tag_dz_q[DIV_LAT-1] ? {tag_sgn_q[DIV_LAT-1], 7'h7F} : div_result_i;
    assign rsp_dz_o  = rsp_dz_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_dz_q  <= '0;
            tag_sgn_q <= '0;
            rsp_dz_q  <= '0;
        end else begin
            for (int s = DIV_LAT-1; s > 0; s--) begin
                tag_dz_q[s]  <= tag_dz_q[s-1];
                tag_sgn_q[s] <= tag_sgn_q[s-1];
            end
            tag_dz_q[0]  <= issue_w && (win_b_w[6:0] == 7'd0);
            tag_sgn_q[0] <= win_a_w[7] ^ win_b_w[7];
            for (int i = 0; i < NUM_REQ; i++) begin
                if (cap_w && (cap_id_w == ID_W'(i))) begin
                    rsp_dz_q[i] <= tag_dz_q[DIV_LAT-1];
                end else if (rsp_hs_w[i]) begin
                    rsp_dz_q[i] <= 1'b0;
                end
            end
        end
    end
`else
    assign cap_res_w = div_result_i;
    assign rsp_dz_o  = '0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q       <= '0;
            last_grant_q <= ID_W'(NUM_REQ-1);
            tag_vld_q    <= '0;
            tag_id_q     <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
        end else begin
            busy_q <= busy_d;
            if (issue_w) begin
                last_grant_q <= grant_id_w;
            end
            for (int s = DIV_LAT-1; s > 0; s--) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_id_q[s]  <= tag_id_q[s-1];
            end
            tag_vld_q[0] <= issue_w;
            tag_id_q[0]  <= grant_id_w;
            // One op in flight per requester, so capture and handshake never hit one slot together.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (cap_w && (cap_id_w == ID_W'(i))) begin
                    rsp_valid_q[i]  <= 1'b1;
                    rsp_result_q[i] <= cap_res_w;
                end else if (rsp_hs_w[i]) begin
                    rsp_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    assign req_ready_o  = grant_oh_w;
    assign div_valid_o  = issue_w;
    assign div_a_o      = win_a_w;
    assign div_b_o      = win_b_w;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_result_o = rsp_result_q;

endmodule
`default_nettype wire

// File: tb/tb_fp8_div_sched.sv
`default_nettype none
// Testbench for fp8_div_sched: random traffic against a transaction-level model
// with a stub fixed-latency divider; covers reset, grant order, backpressure, dz.
module tb_fp8_div_sched;
    localparam int NR  = 4;
    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [8*NR-1:0] req_a;
    logic [8*NR-1:0] req_b;
    logic [NR-1:0]   rsp_valid;
    logic [NR-1:0]   rsp_ready;
    logic [8*NR-1:0] rsp_result;
    logic [NR-1:0]   rsp_dz;
    logic            div_valid;
    logic [7:0]      div_a;
    logic [7:0]      div_b;
    logic [7:0]      div_result;

    fp8_div_sched #(.NUM_REQ(NR), .DIV_LAT(LAT)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_result_o (rsp_result),
        .rsp_dz_o     (rsp_dz),
        .div_valid_o  (div_valid),
        .div_a_o      (div_a),
        .div_b_o      (div_b),
        .div_result_i (div_result)
    );

    always #5 clk = ~clk;

    // Stand-in divider: any deterministic function with the right latency will do.
    function automatic logic [7:0] stub_div(input logic [7:0] a, input logic [7:0] b);
        return (a ^ {b[2:0], b[7:3]}) + 8'h35;
    endfunction

    logic [7:0] div_pipe [LAT];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < LAT; s++) div_pipe[s] <= 8'h00;
        end else begin
            for (int s = LAT-1; s > 0; s--) div_pipe[s] <= div_pipe[s-1];
            div_pipe[0] <= div_valid ? stub_div(div_a, div_b) : 8'h00;
        end
    end
    assign div_result = div_pipe[LAT-1];

    typedef struct {
        int         due;
        int         id;
        logic [7:0] res;
        bit         dz;
    } op_t;

    op_t        inflight[$];
    bit         m_busy [NR];
    bit         m_rv   [NR];
    bit         m_dz   [NR];
    logic [7:0] m_res  [NR];
    int         m_last;
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic void ref_quot(input logic [7:0] a, input logic [7:0] b,
                                     output logic [7:0] q, output bit dz);
`ifdef FP8_DIV_SCHED_DIVZERO_EN
        dz = (b[6:0] == 7'd0);
`else
        dz = 1'b0;
`endif
        q = dz ? {a[7] ^ b[7], 7'h7F} : stub_div(a, b);
    endfunction

    task automatic model_reset();
        inflight.delete();
        m_last = NR-1;
        for (int i = 0; i < NR; i++) begin
            m_busy[i] = 1'b0;
            m_rv[i]   = 1'b0;
            m_dz[i]   = 1'b0;
            m_res[i]  = 8'h00;
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NR; i++) begin
            req_a[8*i +: 8] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) req_b[8*i +: 8] = {1'($urandom), 7'h00};
            else                            req_b[8*i +: 8] = 8'($urandom);
        end
    endtask

    // One clock: check outputs at the falling edge, advance the model at the rising edge.
    task automatic tick();
        int         w;
        logic [NR-1:0] exp_rdy, exp_rv, exp_dz;
        logic [7:0] exp_a, exp_b, q;
        bit         dz;
        op_t        op;
        w = -1;
        @(negedge clk);
        if (!rst_n) begin
            check_eq("rst_req_ready", 32'(req_ready), 32'h0);
            check_eq("rst_div_valid", 32'(div_valid), 32'h0);
            check_eq("rst_div_a", 32'(div_a), 32'h0);
            check_eq("rst_div_b", 32'(div_b), 32'h0);
            check_eq("rst_rsp_valid", 32'(rsp_valid), 32'h0);
            check_eq("rst_rsp_result", rsp_result, 32'h0);
            check_eq("rst_rsp_dz", 32'(rsp_dz), 32'h0);
        end else begin
            for (int k = 1; k <= NR; k++) begin
                int idx;
                idx = (m_last + k) % NR;
                if (w < 0 && req_valid[idx] && !m_busy[idx]) w = idx;
            end
            exp_rdy = '0;
            exp_a   = 8'h00;
            exp_b   = 8'h00;
            if (w >= 0) begin
                exp_rdy[w] = 1'b1;
                exp_a = req_a[8*w +: 8];
                exp_b = req_b[8*w +: 8];
            end
            check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
            check_eq("div_valid", 32'(div_valid), 32'(w >= 0));
            check_eq("div_a", 32'(div_a), 32'(exp_a));
            check_eq("div_b", 32'(div_b), 32'(exp_b));
            for (int i = 0; i < NR; i++) begin
                exp_rv[i] = m_rv[i];
                exp_dz[i] = m_dz[i];
                if (m_rv[i]) check_eq($sformatf("rsp_result%0d", i), 32'(rsp_result[8*i +: 8]), 32'(m_res[i]));
            end
            check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            check_eq("rsp_dz", 32'(rsp_dz), 32'(exp_dz));
        end
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (m_rv[i] && rsp_ready[i]) begin
                    m_rv[i]   = 1'b0;
                    m_dz[i]   = 1'b0;
                    m_busy[i] = 1'b0;
                end
            end
            while (inflight.size() > 0 && inflight[0].due == cyc) begin
                op = inflight.pop_front();
                m_rv[op.id]  = 1'b1;
                m_res[op.id] = op.res;
                m_dz[op.id]  = op.dz;
            end
            if (w >= 0) begin
                ref_quot(exp_a, exp_b, q, dz);
                m_busy[w] = 1'b1;
                m_last    = w;
                inflight.push_back('{due: cyc + LAT, id: w, res: q, dz: dz});
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        model_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        rsp_ready = '1;
        rand_ops();
        #1;
        repeat (3) tick();

        rst_n     = 1'b1;
        req_valid = '0;
        tick();

        // Single op on requester 0
        req_valid    = 4'b0001;
        req_a[7:0]   = 8'h40;
        req_b[7:0]   = 8'h38;
        tick();
        req_valid = '0;
        repeat (5) tick();

        // All four requesters at once
        req_valid = '1;
        rand_ops();
        repeat (8) tick();
        req_valid = '0;
        repeat (5) tick();

        // Backpressure on requester 1 while it keeps requesting
        req_valid = 4'b0010;
        rsp_ready = 4'b1101;
        repeat (14) tick();
        rsp_ready = '1;
        repeat (4) tick();
        req_valid = '0;
        repeat (4) tick();

        // Zero divisor with both operands negative
        req_valid  = 4'b0001;
        req_a[7:0] = 8'hC0;
        req_b[7:0] = 8'h80;
        tick();
        req_valid = '0;
        repeat (5) tick();

        repeat (300) begin
            req_valid = 4'($urandom);
            rsp_ready = 4'($urandom) | 4'($urandom);
            rand_ops();
            tick();
        end

        req_valid = '0;
        rsp_ready = '1;
        repeat (6) tick();

        // Reset one cycle after issuing requester 2
        req_valid = 4'b0100;
        rand_ops();
        tick();
        rst_n     = 1'b0;
        req_valid = '1;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fp8_div_sched.md
# fp8_div_sched

Round-robin scheduler that shares one pipelined FP8 (E4M3, sign/4-bit exponent/3-bit mantissa) divide datapath among `NUM_REQ` requesters. It accepts at most one operation per cycle and drives the divider's operand and valid lines. It tracks in-flight requester IDs in a `DIV_LAT`-deep tag pipeline and returns each result to its requester through a one-entry response register. It sits between the attention/normalisation requesters and the single shared divider instance.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters. Range 2..8.
- `DIV_LAT`, default 2: divider latency in cycles, operand valid to `div_result_i` valid. Minimum 1.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `req_valid_i`  in  NUM_REQ  per-requester request valid.
- `req_ready_o`  out  NUM_REQ  per-requester accept; one-hot or zero.
- `req_a_i`  in  8*NUM_REQ  dividend; requester i uses bits [8i+7:8i].
- `req_b_i`  in  8*NUM_REQ  divisor; same packing as `req_a_i`.
- `rsp_valid_o`  out  NUM_REQ  response held for requester i.
- `rsp_ready_i`  in  NUM_REQ  requester consumes its response.
- `rsp_result_o`  out  8*NUM_REQ  quotient, packed per requester.
- `rsp_dz_o`  out  NUM_REQ  divide-by-zero flag for the response.
- `div_valid_o`  out  1  operand issue strobe to the divider.
- `div_a_o`, `div_b_o`  out  8 each  operands to the divider.
- `div_result_i`  in  8  divider output, valid `DIV_LAT` cycles after issue.

## Operation
- Requester i is eligible when `req_valid_i[i]` is 1 and `busy[i]` is 0. `busy[i]` is set when i is issued and cleared when its response handshake completes.
- Arbitration is round-robin over eligible requesters:
  - The search starts at `last_grant+1` and wraps from `NUM_REQ-1` to 0.
  - `last_grant` resets to `NUM_REQ-1`, so requester 0 has priority first.
  - `last_grant` updates only on an issue.
- `req_ready_o[i]` is 1 only for the winner, combinationally. An issue is `req_valid_i[i] & req_ready_o[i]`.
- On an issue:
  - `div_valid_o` is 1 in the same cycle.
  - `div_a_o`/`div_b_o` carry the winner's operands. They are 0 when there is no issue.
  - The tag pipeline shifts in {valid, id, dz}.
- When the tag pipeline output is valid, `div_result_i` is captured into `rsp_result_o[id]` and `rsp_valid_o[id]` is set.
- `rsp_valid_o[i]` stays high, with the result held stable, until `rsp_ready_i[i]` is 1 at a clock edge.
- Each requester has one op in flight, so response slots can never collide.
- Mid-operation reset clears all tags, `busy`, and responses. In-flight results are discarded. The divider must be reset together with this block.

## Timing
- Reset values:
  - All outputs are 0.
  - `busy` is all-zero and tags are invalid.
  - `last_grant` is `NUM_REQ-1`.
- Latency: issue at cycle t, `div_result_i` sampled at the end of cycle t+`DIV_LAT`, `rsp_valid_o` high from cycle t+`DIV_LAT`+1.
- A response handshake and a new `req_valid_i` from the same requester in the same cycle: the new request is accepted no earlier than the next cycle, because `busy` clears at the edge.
- Per-requester throughput is 1 op per `DIV_LAT`+2 cycles. Aggregate throughput is 1 op per cycle.
- `req_valid_i` may drop without acceptance. The scheduler has no requirement on it.

## Configuration
- Macro: `FP8_DIV_SCHED_DIVZERO_EN`.
- Defined:
  - At issue, a divisor with `req_b_i[6:0]==0` sets the tag's dz bit.
  - The operation still occupies a divider slot, for fixed timing.
  - On return, `rsp_result_o` is forced to `{a[7]^b[7], 7'h7F}` and `rsp_dz_o[id]`=1. The sign bits are held in the tag.
  - `rsp_dz_o` clears on the response handshake.
- Undefined:
  - No detection; `rsp_result_o` is always `div_result_i`.
  - `rsp_dz_o` is tied to 0 and the tag has no dz or sign bits.

## Test plan
- Single op: req0 with a=8'h40, b=8'h38 at t=1, `DIV_LAT`=2 → `div_valid_o`=1, `div_a_o`=8'h40 at t=1; `rsp_valid_o[0]`=1 at t=4 holding the model result.
- All 4 requesters valid from reset → grants in order 0,1,2,3 on consecutive cycles; `rsp_valid_o` rises at cycles 4,5,6,7; no grant goes to a busy requester.
- Backpressure: `rsp_ready_i[1]`=0 for 10 cycles with req1 valid again → `req_ready_o[1]`=0 throughout; the result is held stable; req1 is re-accepted the cycle after `rsp_ready_i[1]` rises.
- Divide by zero: a=8'hC0, b=8'h80, macro defined → `rsp_result_o`=8'h7F and `rsp_dz_o`=1. Macro undefined → result equals `div_result_i` and `rsp_dz_o`=0.
- Reset mid-flight: assert `rst_ni`=0 one cycle after issuing req2 → every output is 0 during reset; after release no stale `rsp_valid_o` appears, and req0 wins first.
